glb_cfg_initiator: RTL and testbench

- Master end of the tile configuration chain: converts single host register requests into cfg_ifc write/read transactions toward the first GLB tile's slave port.
- Sits between the top-level register bus (AXI-lite bridge) and tile 0's west config port.
- Returns each transaction's completion, read data and error status to the host over a valid/ready response channel.
- One transaction outstanding at a time.

---
 rtl/global_buffer_pkg.sv | 16 +
 rtl/glb_cfg_initiator_if.sv | 44 ++++
 rtl/glb_cfg_initiator.sv | 150 +++++++++++++++
 tb/tb_glb_cfg_initiator.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/global_buffer_pkg.sv
// Shared types and default sizing for the global-buffer configuration initiator.
package global_buffer_pkg;

    localparam int DEF_CFG_ADDR_WIDTH = 32;
    localparam int DEF_CFG_DATA_WIDTH = 32;
    localparam int DEF_RD_TIMEOUT     = 64;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RSP
    } cfg_init_state_e;

endpackage

// File: rtl/glb_cfg_initiator_if.sv
// Host request/response channel plus cfg_ifc write/read port toward tile 0.
interface glb_cfg_initiator_if
    import global_buffer_pkg::*;
#(
    parameter int CFG_ADDR_WIDTH = DEF_CFG_ADDR_WIDTH,
    parameter int CFG_DATA_WIDTH = DEF_CFG_DATA_WIDTH
) ();

    logic                      host_req_valid;
    logic                      host_req_ready;
    logic                      host_req_write;
    logic [CFG_ADDR_WIDTH-1:0] host_req_addr;
    logic [CFG_DATA_WIDTH-1:0] host_req_data;
    logic                      host_rsp_valid;
    logic                      host_rsp_ready;
    logic [CFG_DATA_WIDTH-1:0] host_rsp_data;
    logic                      host_rsp_err;
    logic                      cfg_wr_en;
    logic                      cfg_wr_clk_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_wr_data;
    logic                      cfg_rd_en;
    logic                      cfg_rd_clk_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_rd_data;
    logic                      cfg_rd_data_valid;

    modport master (
        input  host_req_valid, host_req_write, host_req_addr, host_req_data,
        input  host_rsp_ready, cfg_rd_data, cfg_rd_data_valid,
        output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        output cfg_wr_en, cfg_wr_clk_en, cfg_wr_addr, cfg_wr_data,
        output cfg_rd_en, cfg_rd_clk_en, cfg_rd_addr
    );

    modport slave (
        output host_req_valid, host_req_write, host_req_addr, host_req_data,
        output host_rsp_ready, cfg_rd_data, cfg_rd_data_valid,
        input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        input  cfg_wr_en, cfg_wr_clk_en, cfg_wr_addr, cfg_wr_data,
        input  cfg_rd_en, cfg_rd_clk_en, cfg_rd_addr
    );

endinterface

// File: rtl/glb_cfg_initiator.sv
// Single-outstanding host-to-cfg_ifc bridge with read timeout; all outputs registered.
// Optional stray read-valid counter: GLB_CFG_INITIATOR_STRAY_CNT_EN.
module glb_cfg_initiator
    import global_buffer_pkg::*;
#(
    parameter int CFG_ADDR_WIDTH = DEF_CFG_ADDR_WIDTH,
    parameter int CFG_DATA_WIDTH = DEF_CFG_DATA_WIDTH,
    parameter int RD_TIMEOUT     = DEF_RD_TIMEOUT
) (
    input logic                 clk,
    input logic                 reset,
    glb_cfg_initiator_if.master cfg
`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
    ,
    output logic [15:0]         stray_rd_cnt
`endif
);

    localparam int TIMEOUT_WIDTH = $clog2(RD_TIMEOUT + 1);
    localparam logic [TIMEOUT_WIDTH-1:0] LP_TMO = TIMEOUT_WIDTH'(RD_TIMEOUT);

    cfg_init_state_e           r_state, w_state_nxt;
    logic                      r_req_ready, w_req_ready;
    logic                      r_wr_en, w_wr_en;
    logic [CFG_ADDR_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [CFG_DATA_WIDTH-1:0] r_wr_data, w_wr_data;
    logic                      r_rd_en, w_rd_en;
    logic [CFG_ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr;
    logic                      r_rsp_valid, w_rsp_valid;
    logic [CFG_DATA_WIDTH-1:0] r_rsp_data, w_rsp_data;
    logic                      r_rsp_err, w_rsp_err;
    logic [TIMEOUT_WIDTH-1:0]  r_cnt, w_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_wr_addr   = r_wr_addr;
        w_wr_data   = r_wr_data;
        w_rd_addr   = r_rd_addr;
        w_rsp_data  = r_rsp_data;
        w_rsp_err   = r_rsp_err;
        w_cnt       = r_cnt;
        case (r_state)
            IDLE: begin
                if (cfg.host_req_valid) begin
                    if (cfg.host_req_write) begin
                        w_wr_addr   = cfg.host_req_addr;
                        w_wr_data   = cfg.host_req_data;
                        w_state_nxt = WR;
                    end else begin
                        w_rd_addr   = cfg.host_req_addr;
                        w_state_nxt = RD_REQ;
                    end
                end
            end
            WR: begin
                w_rsp_data  = '0;
                w_rsp_err   = 1'b0;
                w_state_nxt = RSP;
            end
            RD_REQ: begin
                w_cnt = TIMEOUT_WIDTH'(1);
                if (cfg.cfg_rd_data_valid) begin
                    w_rsp_data  = cfg.cfg_rd_data;
                    w_rsp_err   = 1'b0;
                    w_state_nxt = RSP;
                end else begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt != LP_TMO) w_cnt = r_cnt + 1'b1;
                // Data arriving on the timeout cycle still counts as a good read.
                if (cfg.cfg_rd_data_valid) begin
                    w_rsp_data  = cfg.cfg_rd_data;
                    w_rsp_err   = 1'b0;
                    w_state_nxt = RSP;
                end else if (r_cnt == LP_TMO) begin
                    w_rsp_data  = '1;
                    w_rsp_err   = 1'b1;
                    w_state_nxt = RSP;
                end
            end
            RSP: begin
                if (cfg.host_rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Outputs are decoded from the next state so they register in step with it.
        w_req_ready = (w_state_nxt == IDLE);
        w_wr_en     = (w_state_nxt == WR);
        w_rd_en     = (w_state_nxt == RD_REQ);
        w_rsp_valid = (w_state_nxt == RSP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= w_req_ready;
            r_wr_en     <= w_wr_en;
            r_wr_addr   <= w_wr_addr;
            r_wr_data   <= w_wr_data;
            r_rd_en     <= w_rd_en;
            r_rd_addr   <= w_rd_addr;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
            r_cnt       <= w_cnt;
        end
    end

    assign cfg.host_req_ready = r_req_ready;
    assign cfg.host_rsp_valid = r_rsp_valid;
    assign cfg.host_rsp_data  = r_rsp_data;
    assign cfg.host_rsp_err   = r_rsp_err;
    assign cfg.cfg_wr_en      = r_wr_en;
    assign cfg.cfg_wr_clk_en  = r_wr_en;
    assign cfg.cfg_wr_addr    = r_wr_addr;
    assign cfg.cfg_wr_data    = r_wr_data;
    assign cfg.cfg_rd_en      = r_rd_en;
    assign cfg.cfg_rd_clk_en  = r_rd_en;
    assign cfg.cfg_rd_addr    = r_rd_addr;

`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
    logic [15:0] r_stray_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stray_cnt <= '0;
        end else if (cfg.cfg_rd_data_valid && (r_state != RD_REQ) && (r_state != RD_WAIT)
                     && (r_stray_cnt != 16'hFFFF)) begin
            r_stray_cnt <= r_stray_cnt + 16'd1;
        end
    end

    assign stray_rd_cnt = r_stray_cnt;
`endif

endmodule

// File: tb/tb_glb_cfg_initiator.sv
// Randomized bench for glb_cfg_initiator: a per-transaction timeline model predicts every output each cycle.
module tb_glb_cfg_initiator;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    glb_cfg_initiator_if #(.CFG_ADDR_WIDTH(AW), .CFG_DATA_WIDTH(DW)) ifc ();

`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
    logic [15:0] stray_rd_cnt;
`endif

    glb_cfg_initiator #(
        .CFG_ADDR_WIDTH(AW),
        .CFG_DATA_WIDTH(DW),
        .RD_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .cfg(ifc)
`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
        ,
        .stray_rd_cnt(stray_rd_cnt)
`endif
    );

    // Timeline model of the current transaction: accept T, strobe S, response R..H.
    bit          have_txn = 0;
    bit          m_wr;
    int          m_T, m_S, m_R, m_H;
    logic [31:0] m_addr, m_data, m_rdata;
    logic        m_err;
    logic [31:0] exp_wa = '0, exp_wd = '0, exp_ra = '0;
    int          exp_stray = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit e_ready, e_wr, e_rd, e_rv, in_rd_window;
            e_ready = !(have_txn && cyc > m_T && cyc <= m_H);
            e_wr    = have_txn && m_wr && cyc == m_S;
            e_rd    = have_txn && !m_wr && cyc == m_S;
            e_rv    = have_txn && cyc >= m_R && cyc <= m_H;
            if (e_wr) begin exp_wa = m_addr; exp_wd = m_data; end
            if (e_rd) exp_ra = m_addr;
            chk("req_ready", ifc.host_req_ready, e_ready);
            chk("wr_en", ifc.cfg_wr_en, e_wr);
            chk("wr_clk_en", ifc.cfg_wr_clk_en, e_wr);
            chk("rd_en", ifc.cfg_rd_en, e_rd);
            chk("rd_clk_en", ifc.cfg_rd_clk_en, e_rd);
            chk("wr_addr", ifc.cfg_wr_addr, exp_wa);
            chk("wr_data", ifc.cfg_wr_data, exp_wd);
            chk("rd_addr", ifc.cfg_rd_addr, exp_ra);
            chk("rsp_valid", ifc.host_rsp_valid, e_rv);
            if (e_rv) begin
                chk("rsp_data", ifc.host_rsp_data, m_rdata);
                chk("rsp_err", ifc.host_rsp_err, m_err);
            end
            in_rd_window = have_txn && !m_wr && cyc >= m_S && cyc < m_R;
`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
            chk("stray_cnt", stray_rd_cnt, exp_stray);
`endif
            if (ifc.cfg_rd_data_valid && !in_rd_window && exp_stray < 65535) exp_stray++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int pct);
        repeat (n) begin
            ifc.host_req_valid    = 1'b0;
            ifc.host_req_write    = 1'($urandom_range(1));
            ifc.host_req_addr     = $urandom;
            ifc.cfg_rd_data_valid = ($urandom_range(99) < pct);
            ifc.cfg_rd_data       = $urandom;
            ifc.host_rsp_ready    = 1'($urandom_range(1));
            step();
        end
        ifc.cfg_rd_data_valid = 1'b0;
    endtask

    // lat: cycles after cfg_rd_en at which the slave answers; lat > TMO means never.
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input int dly,
                          output int o_stb, output int o_nstb, output int o_rsp,
                          output int o_nrsp, output logic [31:0] o_data, output logic o_err);
        int t, c;
        while (have_txn && cyc <= m_H) step();
        t = cyc;
        m_wr = wr; m_addr = a; m_data = d; m_T = t; m_S = t + 1;
        m_R = t + 2 + (wr ? 0 : ((lat < TMO) ? lat : TMO));
        m_H = m_R + dly;
        m_rdata = wr ? 32'h0 : ((lat <= TMO) ? d : 32'hFFFF_FFFF);
        m_err = !wr && (lat > TMO);
        have_txn = 1;
        o_stb = -1; o_nstb = 0; o_rsp = -1; o_nrsp = 0; o_data = '0; o_err = 1'b0;
        ifc.host_req_valid = 1'b1;
        ifc.host_req_write = wr;
        ifc.host_req_addr  = a;
        ifc.host_req_data  = wr ? d : $urandom;
        while (cyc <= m_H) begin
            c = cyc;
            if (c > t) begin
                ifc.host_req_valid = 1'b0;
                ifc.host_req_write = 1'($urandom_range(1));
                ifc.host_req_addr  = $urandom;
                ifc.host_req_data  = $urandom;
            end
            ifc.cfg_rd_data_valid = (!wr && lat <= TMO && c == m_S + lat) ||
                                    (c >= m_R && $urandom_range(7) == 0);
            ifc.cfg_rd_data    = (!wr && c == m_S + lat) ? d : $urandom;
            ifc.host_rsp_ready = (c == m_H) || (c < m_R && $urandom_range(1) == 1);
            if (ifc.cfg_wr_en || ifc.cfg_rd_en) begin
                if (o_stb < 0) o_stb = c - t;
                o_nstb++;
            end
            if (ifc.host_rsp_valid) begin
                if (o_rsp < 0) begin
                    o_rsp = c - t; o_data = ifc.host_rsp_data; o_err = ifc.host_rsp_err;
                end
                o_nrsp++;
            end
            step();
        end
        ifc.host_req_valid    = 1'b0;
        ifc.cfg_rd_data_valid = 1'b0;
        ifc.host_rsp_ready    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int stb, nstb, rsp, nrsp, lat, dly, r;
        logic [31:0] dat;
        logic err;
        bit wr;

        ifc.host_req_valid = 1'b0; ifc.host_req_write = 1'b0;
        ifc.host_req_addr = '0; ifc.host_req_data = '0;
        ifc.host_rsp_ready = 1'b0; ifc.cfg_rd_data = '0; ifc.cfg_rd_data_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk_en = 1;

        // Stray valids while idle: no response, counter (if present) reaches 3.
        repeat (3) begin
            ifc.cfg_rd_data_valid = 1'b1; ifc.cfg_rd_data = $urandom; step();
            ifc.cfg_rd_data_valid = 1'b0; step();
        end
`ifdef GLB_CFG_INITIATOR_STRAY_CNT_EN
        chk("stray_three", stray_rd_cnt, 16'd3);
`endif

        do_txn(1, 32'h0000_0010, 32'hA5A5_0001, 0, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("wr_stb_at", stb, 1); chk("wr_stb_len", nstb, 1);
        chk("wr_rsp_at", rsp, 2); chk("wr_rsp_data", dat, 0); chk("wr_rsp_err", err, 0);

        do_txn(0, 32'h0000_0014, 32'h1234_5678, 1, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("rd_stb_at", stb, 1); chk("rd_stb_len", nstb, 1);
        chk("rd_rsp_at", rsp, 3); chk("rd_rsp_data", dat, 32'h1234_5678); chk("rd_rsp_err", err, 0);

        do_txn(0, 32'h0000_0020, 32'hDEAD_BEEF, TMO + 10, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("tmo_delay", rsp - stb, 65); chk("tmo_data", dat, 32'hFFFF_FFFF); chk("tmo_err", err, 1);

        do_txn(0, 32'h0000_0024, 32'h0BAD_CAFE, TMO, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("edge_delay", rsp - stb, 65); chk("edge_data", dat, 32'h0BAD_CAFE); chk("edge_err", err, 0);

        do_txn(0, 32'h0000_0028, 32'h5555_AAAA, 0, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("rd0_rsp_at", rsp, 2); chk("rd0_data", dat, 32'h5555_AAAA);

        do_txn(1, 32'h0000_0030, 32'h0000_00FF, 0, 10, stb, nstb, rsp, nrsp, dat, err);
        chk("stall_len", nrsp, 11);
        do_txn(1, 32'h0000_0034, 32'h0000_0100, 0, 0, stb, nstb, rsp, nrsp, dat, err);
        chk("b2b_stb_at", stb, 1);

        for (int i = 0; i < 150; i++) begin
            wr  = 1'($urandom_range(1));
            r   = $urandom_range(15);
            lat = (r == 0) ? TMO + 1 + $urandom_range(5) : (r == 1) ? TMO : $urandom_range(6);
            dly = ($urandom_range(3) == 0) ? $urandom_range(12) : 0;
            do_txn(wr, $urandom, $urandom, lat, dly, stb, nstb, rsp, nrsp, dat, err);
            if ($urandom_range(2) == 0) idle($urandom_range(4), 30);
        end

        // Reset in the middle of a read wait aborts the read with no response.
        while (have_txn && cyc <= m_H) step();
        chk_en = 0;
        ifc.host_req_valid = 1'b1; ifc.host_req_write = 1'b0; ifc.host_req_addr = 32'h0000_0040;
        step();
        ifc.host_req_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_busy", ifc.host_req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", ifc.host_req_ready, 1);
        chk("rst_rd_en", ifc.cfg_rd_en, 0);
        chk("rst_wr_en", ifc.cfg_wr_en, 0);
        chk("rst_rsp_valid", ifc.host_rsp_valid, 0);
        chk("rst_rd_addr", ifc.cfg_rd_addr, 0);
        chk("rst_wr_addr", ifc.cfg_wr_addr, 0);
        chk("rst_rsp_data", ifc.host_rsp_data, 0);
        chk("rst_rsp_err", ifc.host_rsp_err, 0);
        repeat (2) step();
        rst_n = 1'b1;
        have_txn = 0; exp_wa = '0; exp_wd = '0; exp_ra = '0; exp_stray = 0;
        step();
        chk_en = 1;
        ifc.cfg_rd_data_valid = 1'b1; ifc.cfg_rd_data = 32'h7777_7777;
        step();
        idle(10, 0);

        do_txn(0, 32'h0000_0044, 32'hCAFE_0001, 2, 1, stb, nstb, rsp, nrsp, dat, err);
        chk("post_rst_data", dat, 32'hCAFE_0001);
        step();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
